// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter that multiplexes two requesters onto a single AES cipher core,
// keeping one job in flight and aborting it with an error response on timeout.
module aes_core_arbiter #(
   parameter int TIMEOUT = 31
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [127:0] req0_key,
   input  logic [127:0] req0_text,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [127:0] req1_key,
   input  logic [127:0] req1_text,
   output logic         core_ld,
   output logic [127:0] core_key,
   output logic [127:0] core_text_in,
   input  logic         core_done,
   input  logic [127:0] core_text_out,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [127:0] rsp_data,
   output logic         rsp_err
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_BUSY = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [CW-1:0] TMO    = CW'(TIMEOUT);
   // TIMEOUT is expected to be at least 1; the abort fires in the cycle the count reaches it
   localparam logic [CW-1:0] TMO_M1 = CW'(TIMEOUT - 1);

   logic [1:0]    state_r;
   logic [CW-1:0] cnt_r;
   logic          ptr_r;      // requester favoured when both are pending
   logic          grant_s;
   logic          gnt_vld_s;
   logic          tmo_hit_s;

   // Grant selection and ready generation; only IDLE ever accepts a request
   always_comb begin
      grant_s    = 1'b0;
      gnt_vld_s  = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (state_r == S_IDLE) begin
         if (req0_valid && req1_valid) begin
            gnt_vld_s = 1'b1;
            grant_s   = ptr_r;
         end else if (req0_valid) begin
            gnt_vld_s = 1'b1;
            grant_s   = 1'b0;
         end else if (req1_valid) begin
            gnt_vld_s = 1'b1;
            grant_s   = 1'b1;
         end else begin
            gnt_vld_s = 1'b0;
            grant_s   = 1'b0;
         end
         req0_ready = gnt_vld_s & ~grant_s;
         req1_ready = gnt_vld_s & grant_s;
      end else begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
      end
   end

   // Timeout detection: the increment performed this cycle would reach TIMEOUT
   always_comb begin
      tmo_hit_s = 1'b0;
      if (cnt_r >= TMO_M1) begin
         tmo_hit_s = 1'b1;
      end else begin
         tmo_hit_s = 1'b0;
      end
   end

   // Job sequencing FSM with registered core and response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= S_IDLE;
         cnt_r        <= '0;
         ptr_r        <= 1'b0;
         core_ld      <= 1'b0;
         core_key     <= 128'd0;
         core_text_in <= 128'd0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_data     <= 128'd0;
         rsp_err      <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (gnt_vld_s) begin
                  core_key     <= grant_s ? req1_key : req0_key;
                  core_text_in <= grant_s ? req1_text : req0_text;
                  rsp_id       <= grant_s;
                  ptr_r        <= ~grant_s;
                  core_ld      <= 1'b1;
                  state_r      <= S_LOAD;
               end else begin
                  core_ld <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            S_LOAD: begin
               core_ld <= 1'b0;
               cnt_r   <= '0;
               state_r <= S_BUSY;
            end
            S_BUSY: begin
               if (cnt_r != TMO) begin
                  cnt_r <= cnt_r + CW'(1);
               end else begin
                  cnt_r <= cnt_r;
               end
               // A completion coinciding with the timeout still counts as success
               if (core_done) begin
                  rsp_data  <= core_text_out;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state_r   <= S_RESP;
               end else if (tmo_hit_s) begin
                  rsp_data  <= 128'd0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state_r   <= S_RESP;
               end else begin
                  state_r <= S_BUSY;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_r   <= S_IDLE;
               end else begin
                  rsp_valid <= 1'b1;
                  state_r   <= S_RESP;
               end
            end
            default: begin
               core_ld   <= 1'b0;
               rsp_valid <= 1'b0;
               state_r   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter: directed scenarios plus randomized jobs
// checked against a transaction-level model of arbitration, latency and timeout.
module tb_aes_core_arbiter;

   localparam int TMO = 31;

   logic         clk;
   logic         rst;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [127:0] req0_key, req0_text, req1_key, req1_text;
   logic         core_ld;
   logic [127:0] core_key, core_text_in;
   logic         core_done;
   logic [127:0] core_text_out;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [127:0] rsp_data;

   int n_cmp;
   int n_fail;
   logic rr_next;   // model: requester favoured on a tie

   aes_core_arbiter #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_text(req0_text),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_text(req1_text),
      .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
      .core_done(core_done), .core_text_out(core_text_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One full job: request, core run of 'lat' cycles after core_ld (lat > TMO: never in time),
   // optional spurious done in LOAD, then 'hold' cycles of back-pressure on the response.
   task automatic do_job(input logic v0, input logic v1, input int lat, input bit early,
                         input int hold, input bit keep_valid, input logic [127:0] cipher);
      logic         exp_id;
      logic         exp_err;
      logic [127:0] ek, et, ed;
      int           exp_k;
      req0_valid = v0;
      req1_valid = v1;
      core_done  = 1'b0;
      rsp_ready  = 1'b0;
      exp_id     = (v0 && v1) ? rr_next : v1;
      #1;
      chk1("grant_ready0", req0_ready, ~exp_id);
      chk1("grant_ready1", req1_ready, exp_id);
      ek      = exp_id ? req1_key : req0_key;
      et      = exp_id ? req1_text : req0_text;
      rr_next = ~exp_id;
      tick;
      if (!keep_valid) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
      chk1("core_ld_pulse", core_ld, 1'b1);
      chk128("core_key", core_key, ek);
      chk128("core_text_in", core_text_in, et);
      if (early) begin
         core_done     = 1'b1;
         core_text_out = rnd128();
      end
      exp_err = !(lat >= 1 && lat <= TMO);
      exp_k   = exp_err ? TMO + 1 : lat + 1;
      ed      = exp_err ? 128'd0 : cipher;
      for (int k = 1; k <= exp_k; k++) begin
         tick;
         core_done = 1'b0;
         chk1("core_ld_low", core_ld, 1'b0);
         chk1("rsp_valid_timing", rsp_valid, (k == exp_k));
         chk1("busy_ready0", req0_ready, 1'b0);
         chk1("busy_ready1", req1_ready, 1'b0);
         if (k == lat) begin
            core_done     = 1'b1;
            core_text_out = cipher;
         end
      end
      chk1("rsp_id", rsp_id, exp_id);
      chk1("rsp_err", rsp_err, exp_err);
      chk128("rsp_data", rsp_data, ed);
      for (int h = 0; h < hold; h++) begin
         core_done     = 1'($urandom_range(0, 1));
         core_text_out = rnd128();
         tick;
         chk1("hold_valid", rsp_valid, 1'b1);
         chk1("hold_id", rsp_id, exp_id);
         chk1("hold_err", rsp_err, exp_err);
         chk128("hold_data", rsp_data, ed);
         chk1("hold_ready0", req0_ready, 1'b0);
         chk1("hold_ready1", req1_ready, 1'b0);
      end
      core_done = 1'b0;
      rsp_ready = 1'b1;
      #1;
      chk1("hs_ready0", req0_ready, 1'b0);
      chk1("hs_ready1", req1_ready, 1'b0);
      tick;
      rsp_ready = 1'b0;
      chk1("rsp_valid_drop", rsp_valid, 1'b0);
   endtask

   initial begin
      n_cmp         = 0;
      n_fail        = 0;
      rr_next       = 1'b0;
      rst           = 1'b1;
      req0_valid    = 1'b0;
      req1_valid    = 1'b0;
      req0_key      = rnd128();
      req0_text     = rnd128();
      req1_key      = rnd128();
      req1_text     = rnd128();
      core_done     = 1'b0;
      core_text_out = 128'd0;
      rsp_ready     = 1'b0;
      tick;
      tick;
      chk1("rst_core_ld", core_ld, 1'b0);
      chk128("rst_core_key", core_key, 128'd0);
      chk128("rst_core_text", core_text_in, 128'd0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_rsp_id", rsp_id, 1'b0);
      chk128("rst_rsp_data", rsp_data, 128'd0);
      chk1("rst_rsp_err", rsp_err, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick;

      // Both requesters pending continuously: alternate starting from requester 0
      for (int j = 0; j < 4; j++) begin
         req0_key  = rnd128();
         req1_key  = rnd128();
         req0_text = rnd128();
         req1_text = rnd128();
         do_job(1'b1, 1'b1, int'($urandom_range(1, 20)), 1'b0, int'($urandom_range(0, 2)), 1'b1, rnd128());
      end

      // Known AES-128 vector through requester 0
      req0_key  = 128'h000102030405060708090a0b0c0d0e0f;
      req0_text = 128'h00112233445566778899aabbccddeeff;
      do_job(1'b1, 1'b0, 11, 1'b0, 0, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

      do_job(1'b0, 1'b1, 1000, 1'b0, 1, 1'b0, rnd128());          // timeout, no done
      do_job(1'b1, 1'b0, 7, 1'b0, 20, 1'b0, rnd128());            // long back-pressure
      do_job(1'b0, 1'b1, 5, 1'b1, 0, 1'b0, rnd128());             // done in LOAD ignored
      do_job(1'b1, 1'b1, TMO, 1'b0, 0, 1'b0, rnd128());           // done coincides with timeout
      do_job(1'b1, 1'b1, TMO - 1, 1'b0, 0, 1'b0, rnd128());
      do_job(1'b1, 1'b0, TMO + 1, 1'b0, 2, 1'b0, rnd128());       // done arrives in RESP
      do_job(1'b0, 1'b1, 1, 1'b0, 0, 1'b0, rnd128());

      for (int j = 0; j < 14; j++) begin
         logic rv0, rv1;
         int   rl;
         rv0 = 1'($urandom_range(0, 1));
         rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
         rl  = ($urandom_range(0, 5) == 0) ? 1000 : int'($urandom_range(1, TMO + 2));
         req0_key  = rnd128();
         req1_key  = rnd128();
         req0_text = rnd128();
         req1_text = rnd128();
         do_job(rv0, rv1, rl, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), rnd128());
      end

      // Reset in the middle of a job discards it
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      req1_key   = rnd128();
      req1_text  = rnd128();
      tick;
      req1_valid = 1'b0;
      tick;
      tick;
      tick;
      tick;
      #2;
      rst = 1'b1;
      #1;
      chk1("midrst_core_ld", core_ld, 1'b0);
      chk128("midrst_core_key", core_key, 128'd0);
      chk128("midrst_core_text", core_text_in, 128'd0);
      chk1("midrst_rsp_valid", rsp_valid, 1'b0);
      chk1("midrst_rsp_id", rsp_id, 1'b0);
      chk128("midrst_rsp_data", rsp_data, 128'd0);
      chk1("midrst_rsp_err", rsp_err, 1'b0);
      rr_next = 1'b0;
      @(negedge clk);
      rst           = 1'b0;
      core_done     = 1'b1;
      core_text_out = rnd128();
      tick;
      core_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick;
         chk1("post_rst_no_rsp", rsp_valid, 1'b0);
      end
      req0_key  = rnd128();
      req1_key  = rnd128();
      do_job(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, rnd128());             // pointer back on requester 0

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 31: maximum cycles the block waits for core_done after core_ld before it aborts.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req0_valid  in  1  requester 0 has a job pending.
REQ-005 req0_ready  out  1  requester 0 job accepted this cycle.
REQ-006 req0_key  in  128  requester 0 cipher key.
REQ-007 req0_text  in  128  requester 0 plaintext.
REQ-008 req1_valid, req1_ready, req1_key, req1_text: identical to REQ-004..007, for requester 1.
REQ-009 core_ld  out  1  one-cycle load strobe to the AES cipher core.
REQ-010 core_key  out  128  key presented to the core; registered.
REQ-011 core_text_in  out  128  plaintext presented to the core; registered.
REQ-012 core_done  in  1  core completion pulse.
REQ-013 core_text_out  in  128  core ciphertext; valid when core_done=1.
REQ-014 rsp_valid  out  1  response available.
REQ-015 rsp_ready  in  1  consumer accepts the response.
REQ-016 rsp_id  out  1  requester index that owns the response.
REQ-017 rsp_data  out  128  ciphertext, or 0 on error.
REQ-018 rsp_err  out  1  1 = job aborted on timeout.

Function
REQ-019 FSM states: IDLE, LOAD, BUSY, RESP; exactly one core job is in flight at any time.
REQ-020 IDLE, exactly one reqN_valid=1: reqN_ready=1 combinationally in that cycle.
REQ-021 IDLE, both valid: grant goes to the requester not granted last (round-robin); after reset the pointer favours requester 0.
REQ-022 Only the granted requester sees ready=1; reqN_ready=0 in every state other than IDLE.
REQ-023 On a handshake, capture key/text into core_key/core_text_in, record grant id, update last-grant pointer, go to LOAD.
REQ-024 LOAD: core_ld=1 for exactly one cycle, clear the timeout counter, go to BUSY; core_done sampled in LOAD is ignored.
REQ-025 BUSY: counter increments each cycle; core_done=1 captures core_text_out into rsp_data with rsp_err=0, then goes to RESP.
REQ-026 BUSY: when the counter reaches TIMEOUT without core_done, set rsp_data=0 and rsp_err=1, then go to RESP.
REQ-027 If core_done and the counter reaching TIMEOUT coincide, core_done wins (rsp_err=0).
REQ-028 RESP: rsp_valid=1, with rsp_id, rsp_data and rsp_err held stable until the cycle rsp_valid and rsp_ready are both 1; then go to IDLE.
REQ-029 A new request is accepted no earlier than the cycle after the response handshake (IDLE).
REQ-030 Latency: request handshake at cycle N -> core_ld=1 at N+1; core_done at cycle D -> rsp_valid=1 at D+1.
REQ-031 core_done received in IDLE or RESP is ignored and causes no state change.
REQ-032 Counter width is clog2(TIMEOUT+1) bits; the counter saturates and never wraps.

Reset
REQ-033 Asserting rst forces IDLE immediately, from any state including mid-job.
REQ-034 Reset values: core_ld=0, core_key=0, core_text_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, counter=0, round-robin pointer=requester 0.
REQ-035 A job interrupted by reset is discarded; no response is ever issued for it.

Verification
REQ-036 req0 only, key=000102..0F, text=00112233..FF; model core_done 11 cycles after core_ld -> one core_ld pulse; rsp_valid=1 with rsp_id=0, rsp_err=0, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-037 Both valid continuously for 4 jobs -> grant order 0,1,0,1; ready never high in both requesters in the same cycle.
REQ-038 core_done never asserted, TIMEOUT=31 -> rsp_valid 32 cycles after core_ld with rsp_err=1 and rsp_data=0.
REQ-039 rsp_ready held 0 for 20 cycles in RESP -> rsp_valid/rsp_id/rsp_data stable throughout; req0_ready=req1_ready=0 throughout.
REQ-040 rst pulsed in BUSY -> all outputs reach their REQ-034 values before the next edge; a later core_done produces no response.
REQ-041 core_done asserted in the LOAD cycle and again at count 5 -> only the second pulse is captured.
